shift_arbiter: RTL and testbench

//  Shares one combinational barrel_shifter between two requesters (port 0: ALU issue, port 1: addr/agu).

---
 rtl/shift_arbiter_pkg.sv | 19 +
 rtl/barrel_shifter.sv | 36 +++
 rtl/rr_arb2.sv | 28 ++
 rtl/shift_arbiter.sv | 92 +++++++++
 tb/tb_shift_arbiter.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/shift_arbiter_pkg.sv
// Shared definitions for the shift arbiter: shift-mode encodings, shifter geometry
// and a bit-reverse helper.
package shift_arbiter_pkg;

   localparam int SHIFT_W = 32;
   localparam int SHAMT_W = $clog2(SHIFT_W);

   localparam logic [1:0] SHIFT_SLL = 2'b00;
   localparam logic [1:0] SHIFT_SRL = 2'b01;
   localparam logic [1:0] SHIFT_SRA = 2'b10;
   localparam logic [1:0] SHIFT_RSV = 2'b11;

   function automatic logic [SHIFT_W-1:0] bit_rev(input logic [SHIFT_W-1:0] v);
      logic [SHIFT_W-1:0] r;
      for (int i = 0; i < SHIFT_W; i++) r[i] = v[SHIFT_W-1-i];
      return r;
   endfunction

endpackage

// File: rtl/barrel_shifter.sv
// Combinational logarithmic barrel shifter. Left shifts reuse the right-shift
// network by reversing the operand on the way in and out.
module barrel_shifter
   import shift_arbiter_pkg::*;
(
   input  logic [SHIFT_W-1:0] a,
   input  logic [SHAMT_W-1:0] shamt,
   input  logic [1:0]         mode,
   output logic [SHIFT_W-1:0] y
);

   logic                 fill;
   logic [SHIFT_W-1:0]   stage [0:SHAMT_W];
   logic                 is_left;

   assign is_left  = (mode == SHIFT_SLL);
   assign fill     = (mode == SHIFT_SRA) & a[SHIFT_W-1];
   assign stage[0] = is_left ? bit_rev(a) : a;

   for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
      assign stage[k+1] = shamt[k]
         ? {{(1 << k){fill}}, stage[k][SHIFT_W-1:(1 << k)]}
         : stage[k];
   end

   always_comb begin
      y = a;
      case (mode)
         SHIFT_SLL: y = bit_rev(stage[SHAMT_W]);
         SHIFT_SRL,
         SHIFT_SRA: y = stage[SHAMT_W];
         default:   y = a;
      endcase
   end

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The preference pointer moves only when a grant
// is actually consumed, and then points at the port that lost.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] grant
);

   logic ptr;

   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = ptr ? 2'b10 : 2'b01;
         default: grant = 2'b00;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       ptr <= 1'b0;
      else if (advance) ptr <= grant[0];
   end

endmodule

// File: rtl/shift_arbiter.sv
// Shares one barrel shifter between two requesters with round-robin grant and a
// single registered result stage (accept-to-response latency of one cycle).
//
//   state    | meaning
//   ---------+-------------------------------------------------
//   ST_EMPTY | no result held; any granted request is accepted
//   ST_FULL  | result held for owner until rsp_ready[owner]
module shift_arbiter
   import shift_arbiter_pkg::*;
#(
   parameter int W     = 32,
   parameter int TAG_W = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [1:0]           req_valid,
   output logic [1:0]           req_ready,
   input  logic [2*W-1:0]       req_a,
   input  logic [2*SHAMT_W-1:0] req_shamt,
   input  logic [3:0]           req_mode,
   input  logic [2*TAG_W-1:0]   req_tag,
   output logic [1:0]           rsp_valid,
   input  logic [1:0]           rsp_ready,
   output logic [W-1:0]         rsp_y,
   output logic [TAG_W-1:0]     rsp_tag,
   output logic                 rsp_err
);

   localparam logic [0:0] ST_EMPTY = 1'b0;
   localparam logic [0:0] ST_FULL  = 1'b1;

   logic [0:0]         state;
   logic               owner;
   logic [1:0]         grant;
   logic               can_accept;
   logic               fire;
   logic               sel;
   logic [W-1:0]       sel_a;
   logic [SHAMT_W-1:0] sel_shamt;
   logic [1:0]         sel_mode;
   logic [TAG_W-1:0]   sel_tag;
   logic               sel_err;
   logic [W-1:0]       shift_y;

   assign can_accept = (state == ST_EMPTY) | rsp_ready[owner];
   // Gated by rst_n so nothing is accepted while reset is held.
   assign req_ready  = rst_n ? ({2{can_accept}} & grant) : 2'b00;
   assign fire       = |(req_valid & req_ready);

   rr_arb2 u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req_valid),
      .advance (fire),
      .grant   (grant)
   );

   assign sel       = grant[1];
   assign sel_a     = sel ? req_a[2*W-1:W]             : req_a[W-1:0];
   assign sel_shamt = sel ? req_shamt[2*SHAMT_W-1:SHAMT_W] : req_shamt[SHAMT_W-1:0];
   assign sel_mode  = sel ? req_mode[3:2]              : req_mode[1:0];
   assign sel_tag   = sel ? req_tag[2*TAG_W-1:TAG_W]   : req_tag[TAG_W-1:0];
   assign sel_err   = (sel_mode == SHIFT_RSV);

   barrel_shifter u_shift (
      .a     (sel_a),
      .shamt (sel_shamt),
      .mode  (sel_mode),
      .y     (shift_y)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_EMPTY;
         owner   <= 1'b0;
         rsp_y   <= '0;
         rsp_tag <= '0;
         rsp_err <= 1'b0;
      end else if (fire) begin
         state   <= ST_FULL;
         owner   <= sel;
         rsp_y   <= sel_err ? sel_a : shift_y;
         rsp_tag <= sel_tag;
         rsp_err <= sel_err;
      end else if (state == ST_FULL && rsp_ready[owner]) begin
         state   <= ST_EMPTY;
      end
   end

   assign rsp_valid = (state == ST_FULL) ? (owner ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: expected results are queued at accept time
// and checked by a monitor when the owner consumes them.
module tb_shift_arbiter;
   import shift_arbiter_pkg::*;

   localparam int W  = 32;
   localparam int TW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
   logic [2*W-1:0] req_a;
   logic [9:0]    req_shamt;
   logic [3:0]    req_mode;
   logic [2*TW-1:0] req_tag;
   logic [W-1:0]  rsp_y;
   logic [TW-1:0] rsp_tag;
   logic          rsp_err;

   always #5 clk = ~clk;

   shift_arbiter #(.W(W), .TAG_W(TW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_shamt (req_shamt),
      .req_mode  (req_mode),
      .req_tag   (req_tag),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_y     (rsp_y),
      .rsp_tag   (rsp_tag),
      .rsp_err   (rsp_err)
   );

   typedef struct {
      logic [1:0]    port;
      logic [W-1:0]  y;
      logic [TW-1:0] tag;
      logic          err;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [4:0] sh,
                                          input logic [1:0] m);
      case (m)
         2'b00:   return a << sh;
         2'b01:   return a >> sh;
         2'b10:   return $unsigned($signed(a) >>> sh);
         default: return a;
      endcase
   endfunction

   task automatic set_port(input int p, input logic [W-1:0] a, input logic [4:0] sh,
                           input logic [1:0] m, input logic [TW-1:0] t);
      if (p == 0) begin
         req_a[W-1:0] = a; req_shamt[4:0] = sh; req_mode[1:0] = m; req_tag[TW-1:0] = t;
      end else begin
         req_a[2*W-1:W] = a; req_shamt[9:5] = sh; req_mode[3:2] = m; req_tag[2*TW-1:TW] = t;
      end
   endtask

   // Called at posedge+1 with inputs set; checks req_ready, queues any accept.
   task automatic step(input string name, input logic [1:0] exp_ready);
      exp_t e;
      @(negedge clk);
      check(name, req_ready, exp_ready);
      for (int p = 0; p < 2; p++) begin
         if (req_valid[p] && req_ready[p]) begin
            logic [W-1:0] a;
            logic [4:0]   sh;
            logic [1:0]   m;
            a  = req_a[p*W +: W];
            sh = req_shamt[p*5 +: 5];
            m  = req_mode[p*2 +: 2];
            e.port = (p == 0) ? 2'b01 : 2'b10;
            e.y    = model(a, sh, m);
            e.tag  = req_tag[p*TW +: TW];
            e.err  = (m == 2'b11);
            sb.push_back(e);
         end
      end
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (rsp_valid == 2'b11) begin
            n_tests++; n_fail++;
            $display("FAIL rsp_onehot: got %b expected one-hot or zero", rsp_valid);
         end
         if (|(rsp_valid & rsp_ready)) begin
            if (sb.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL sb_underflow: got rsp_valid %b expected no response", rsp_valid);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("rsp_port", rsp_valid, e.port);
               check("rsp_y", rsp_y, e.y);
               check("rsp_tag", rsp_tag, e.tag);
               check("rsp_err", rsp_err, e.err);
            end
         end
      end
   end

   initial begin
      logic [W-1:0] held_y;
      logic [TW-1:0] held_tag;
      logic [W-1:0] ra;

      rst_n = 1'b0; req_valid = '0; req_a = '0; req_shamt = '0; req_mode = '0;
      req_tag = '0; rsp_ready = '0;
      #12;
      check("reset_valid", rsp_valid, 2'b00);
      check("reset_y", rsp_y, 32'h0);
      check("reset_tag", rsp_tag, 4'h0);
      check("reset_err", rsp_err, 1'b0);
      check("reset_ready", req_ready, 2'b00);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Single port SLL 1
      set_port(0, 32'h8000_0001, 5'd1, SHIFT_SLL, 4'h1);
      req_valid = 2'b01; rsp_ready = 2'b01;
      step("p0_ready", 2'b01);
      req_valid = 2'b00;
      check("single_valid", rsp_valid, 2'b01);
      check("single_y", rsp_y, 32'h0000_0002);
      step("idle_ready", 2'b00);

      // Both valid every cycle; pointer now prefers port 1
      rsp_ready = 2'b11; req_valid = 2'b11;
      set_port(0, 32'h0000_00F0, 5'd4, SHIFT_SRL, 4'h3);
      set_port(1, 32'h8000_0001, 5'd1, SHIFT_SRA, 4'h2);
      step("rr_a", 2'b10);
      check("sra_valid", rsp_valid, 2'b10);
      check("sra_y", rsp_y, 32'hC000_0000);
      set_port(1, 32'h8000_0001, 5'd1, SHIFT_SRL, 4'h4);
      step("rr_b", 2'b01);
      check("rr_b_y", rsp_y, 32'h0000_000F);
      step("rr_c", 2'b10);
      check("srl_y", rsp_y, 32'h4000_0000);
      check("srl_tag", rsp_tag, 4'h4);
      step("rr_d", 2'b01);

      // Backpressure; non-owner rsp_ready must be ignored
      req_valid = 2'b01; rsp_ready = 2'b10;
      set_port(0, 32'h1234_5678, 5'd8, SHIFT_SLL, 4'h6);
      held_y = rsp_y; held_tag = rsp_tag;
      check("bp_held_y", held_y, 32'h0000_000F);
      for (int i = 0; i < 3; i++) begin
         step("bp_ready", 2'b00);
         check("bp_y", rsp_y, held_y);
         check("bp_tag", rsp_tag, held_tag);
         check("bp_valid", rsp_valid, 2'b01);
      end
      rsp_ready = 2'b01;
      step("bp_release", 2'b01);
      check("bp_next_y", rsp_y, 32'h3456_7800);
      req_valid = 2'b00; rsp_ready = 2'b11;
      step("bp_drain", 2'b00);

      // Reserved mode on port 1 (preferred), then pointer must move to port 0
      req_valid = 2'b11;
      set_port(1, 32'h1234_5678, 5'd3, SHIFT_RSV, 4'h5);
      set_port(0, 32'h0000_0001, 5'd31, SHIFT_SLL, 4'h7);
      step("rsv_grant", 2'b10);
      check("rsv_y", rsp_y, 32'h1234_5678);
      check("rsv_err", rsp_err, 1'b1);
      check("rsv_tag", rsp_tag, 4'h5);
      step("rsv_adv", 2'b01);
      check("sll31_y", rsp_y, 32'h8000_0000);
      check("sll31_err", rsp_err, 1'b0);

      // Reset asserted while a result is held
      set_port(1, 32'h0000_00FF, 5'd2, SHIFT_SLL, 4'h9);
      step("pre_rst", 2'b10);
      #2 rst_n = 1'b0;
      #1;
      check("rst_valid", rsp_valid, 2'b00);
      check("rst_ready", req_ready, 2'b00);
      check("rst_y", rsp_y, 32'h0);
      sb.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      step("rst_tie_p0", 2'b01);
      req_valid = 2'b00;
      step("rst_drain", 2'b00);

      // Sweep all modes and shift amounts
      for (int m = 0; m < 4; m++) begin
         for (int s = 0; s < 32; s++) begin
            int p;
            p  = s % 2;
            ra = $urandom();
            if (s == 1) ra[W-1] = 1'b1;
            set_port(p, ra, 5'(s), 2'(m), 4'(s));
            req_valid = (p == 0) ? 2'b01 : 2'b10;
            step("sweep_ready", (p == 0) ? 2'b01 : 2'b10);
            if (s == 0) check("shamt0_y", rsp_y, ra);
         end
      end
      req_valid = 2'b00;
      step("end_idle", 2'b00);
      step("end_idle", 2'b00);
      check("sb_empty", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
